// File: rtl/noc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : noc_pkg
// Description : Shared port numbering, port count and flit field-offset
//               helpers for the XY mesh router.
// Revision    : 1.0 - initial release
// ============================================================================
package noc_pkg;

    localparam int NUM_PORTS  = 5;
    localparam int PORT_IDX_W = 3;

    typedef logic [PORT_IDX_W-1:0] port_idx_t;

    // Port numbering: Local, North (y+1), East (x+1), South (y-1), West (x-1)
    localparam port_idx_t PORT_LOCAL = 3'd0;
    localparam port_idx_t PORT_NORTH = 3'd1;
    localparam port_idx_t PORT_EAST  = 3'd2;
    localparam port_idx_t PORT_SOUTH = 3'd3;
    localparam port_idx_t PORT_WEST  = 3'd4;

    // Flit layout is {dest_x, dest_y, payload} with dest_x at the MSBs
    function automatic int flit_width(input int x_w, input int y_w, input int payload_w);
        return x_w + y_w + payload_w;
    endfunction

    function automatic int dest_x_lsb(input int y_w, input int payload_w);
        return y_w + payload_w;
    endfunction

    function automatic int dest_y_lsb(input int payload_w);
        return payload_w;
    endfunction

    // Port index following p, wrapping after the last port
    function automatic port_idx_t next_port(input port_idx_t p);
        return (p == port_idx_t'(NUM_PORTS - 1)) ? PORT_LOCAL : p + port_idx_t'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/noc_fifo.sv
`default_nettype none
// ============================================================================
// Module      : noc_fifo
// Description : Per-input flit FIFO. Registered occupancy count, pointers
//               wrap naturally because DEPTH is a power of two (>= 2).
//               Read data is the head entry, valid whenever empty is low.
// Revision    : 1.0 - initial release
// ============================================================================
module noc_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    push,
    input  logic [WIDTH-1:0]        wdata,
    input  logic                    pop,
    output logic [WIDTH-1:0]        rdata,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push;
    logic             do_pop;

    // Pushes into a full FIFO and pops from an empty one are ignored
    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Next pointer and occupancy values
    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
    end

    // Pointer and count registers
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care while the slot is unoccupied
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mesh_router_xy.sv
`default_nettype none
// ============================================================================
// Module      : mesh_router_xy
// Description : Five-port 2D-mesh router with dimension-ordered (XY) routing.
//               Each input has a FIFO; each output has one flit register fed
//               by a round-robin arbiter over the input heads. A global
//               block_all_paths input freezes all outputs without losing data.
// Revision    : 1.0 - initial release
// ============================================================================
module mesh_router_xy
    import noc_pkg::*;
#(
    parameter int X_W        = 2,
    parameter int Y_W        = 2,
    parameter int PAYLOAD_W  = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int MY_X       = 0,
    parameter int MY_Y       = 0,
    localparam int FLIT_W    = flit_width(X_W, Y_W, PAYLOAD_W)
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          block_all_paths,
    input  logic [NUM_PORTS-1:0]          in_valid,
    input  logic [NUM_PORTS*FLIT_W-1:0]   in_flit,
    output logic [NUM_PORTS-1:0]          in_ready,
    output logic [NUM_PORTS-1:0]          out_valid,
    output logic [NUM_PORTS*FLIT_W-1:0]   out_flit,
    input  logic [NUM_PORTS-1:0]          out_ready,
    output logic                          busy
);

    localparam int             CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int             DX_LSB = dest_x_lsb(Y_W, PAYLOAD_W);
    localparam int             DY_LSB = dest_y_lsb(PAYLOAD_W);
    localparam logic [X_W-1:0] MY_X_C = X_W'(MY_X);
    localparam logic [Y_W-1:0] MY_Y_C = Y_W'(MY_Y);

    // Input side
    logic [FLIT_W-1:0]    head_flit [NUM_PORTS];
    port_idx_t            head_dir  [NUM_PORTS];
    logic [NUM_PORTS-1:0] head_vld;
    logic [NUM_PORTS-1:0] fifo_full;
    logic [NUM_PORTS-1:0] fifo_push;
    logic [NUM_PORTS-1:0] fifo_pop;
    logic [NUM_PORTS-1:0] fifo_used;

    // Output side; grant[o][i] means output o takes the head of input i
    logic [NUM_PORTS-1:0] grant      [NUM_PORTS];
    logic [NUM_PORTS-1:0] can_load;
    logic [NUM_PORTS-1:0] out_vld_vec;
    logic                 out_vld_q  [NUM_PORTS];
    logic                 out_vld_d  [NUM_PORTS];
    logic [FLIT_W-1:0]    out_flit_q [NUM_PORTS];
    logic [FLIT_W-1:0]    out_flit_d [NUM_PORTS];
    port_idx_t            rr_q       [NUM_PORTS];
    port_idx_t            rr_d       [NUM_PORTS];

    // in_ready comes straight from registered FIFO occupancy, so it never
    // depends combinationally on out_ready
    assign in_ready = ~fifo_full;
    assign busy     = (|fifo_used) | (|out_vld_vec);

    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_in
        logic             fifo_empty;
        logic [CNT_W-1:0] fifo_count;
        logic [X_W-1:0]   dest_x;
        logic [Y_W-1:0]   dest_y;

        assign fifo_push[gi] = in_valid[gi] & ~fifo_full[gi];
        // Every input head requests exactly one output, so at most one of
        // these grant terms can be set in a cycle
        assign fifo_pop[gi]  = grant[0][gi] | grant[1][gi] | grant[2][gi]
                             | grant[3][gi] | grant[4][gi];

        noc_fifo #(
            .WIDTH (FLIT_W),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clock (clock),
            .reset (reset),
            .push  (fifo_push[gi]),
            .wdata (in_flit[gi*FLIT_W +: FLIT_W]),
            .pop   (fifo_pop[gi]),
            .rdata (head_flit[gi]),
            .full  (fifo_full[gi]),
            .empty (fifo_empty),
            .count (fifo_count)
        );

        // The head is only ever taken from registered FIFO state, so a flit
        // written this cycle cannot be arbitrated until the next one
        assign head_vld[gi]  = ~fifo_empty;
        assign fifo_used[gi] = (fifo_count != '0);
        assign dest_x        = head_flit[gi][DX_LSB +: X_W];
        assign dest_y        = head_flit[gi][DY_LSB +: Y_W];

        // XY route: resolve the X dimension fully before moving in Y
        always_comb begin
            if (dest_x > MY_X_C) begin
                head_dir[gi] = PORT_EAST;
            end else if (dest_x < MY_X_C) begin
                head_dir[gi] = PORT_WEST;
            end else if (dest_y > MY_Y_C) begin
                head_dir[gi] = PORT_NORTH;
            end else if (dest_y < MY_Y_C) begin
                head_dir[gi] = PORT_SOUTH;
            end else begin
                head_dir[gi] = PORT_LOCAL;
            end
        end
    end

    for (genvar go = 0; go < NUM_PORTS; go++) begin : g_out
        logic [3:0] rr_sum;
        port_idx_t  cand;
        logic       found;

        // Register may take a new flit if empty or draining this very edge;
        // while blocked nothing drains and nothing is granted
        assign can_load[go] = ~block_all_paths & (~out_vld_q[go] | out_ready[go]);

        // Round-robin search starting at rr_q, which points one past the
        // input granted last time
        always_comb begin
            grant[go]      = '0;
            found          = 1'b0;
            rr_sum         = '0;
            cand           = PORT_LOCAL;
            rr_d[go]       = rr_q[go];
            out_flit_d[go] = out_flit_q[go];
            out_vld_d[go]  = out_vld_q[go] & ~(out_valid[go] & out_ready[go]);
            for (int k = 0; k < NUM_PORTS; k++) begin
                rr_sum = {1'b0, rr_q[go]} + 4'(k);
                if (rr_sum >= 4'(NUM_PORTS)) begin
                    rr_sum = rr_sum - 4'(NUM_PORTS);
                end
                cand = rr_sum[PORT_IDX_W-1:0];
                if (!found && can_load[go] && head_vld[cand]
                        && (head_dir[cand] == port_idx_t'(go))) begin
                    found           = 1'b1;
                    grant[go][cand] = 1'b1;
                    out_vld_d[go]   = 1'b1;
                    out_flit_d[go]  = head_flit[cand];
                    rr_d[go]        = next_port(cand);
                end
            end
        end

        // Output flit register and arbitration pointer
        always_ff @(posedge clock) begin
            if (reset) begin
                out_vld_q[go]  <= 1'b0;
                out_flit_q[go] <= '0;
                rr_q[go]       <= PORT_LOCAL;
            end else begin
                out_vld_q[go]  <= out_vld_d[go];
                out_flit_q[go] <= out_flit_d[go];
                rr_q[go]       <= rr_d[go];
            end
        end

        // Held flits stay in the register while blocked and reappear as
        // soon as the block is released
        assign out_valid[go]                 = out_vld_q[go] & ~block_all_paths;
        assign out_flit[go*FLIT_W +: FLIT_W] = out_flit_q[go];
        assign out_vld_vec[go]               = out_vld_q[go];
    end

endmodule
`default_nettype wire

// File: tb/tb_mesh_router_xy.sv
`default_nettype none
// ============================================================================
// Module      : tb_mesh_router_xy
// Description : Self-checking bench for mesh_router_xy at mesh position
//               (1,1). Accepted input flits are queued with the output the
//               XY rule selects; a monitor matches every delivered flit
//               against the oldest pending flit from each source.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mesh_router_xy;

    localparam int MX = 1;
    localparam int MY = 1;
    localparam int FW = 12;
    localparam int NP = 5;

    logic          clock = 1'b0;
    logic          reset;
    logic          block_all_paths;
    logic [NP-1:0] in_valid;
    logic [NP*FW-1:0] in_flit;
    logic [NP-1:0] in_ready;
    logic [NP-1:0] out_valid;
    logic [NP*FW-1:0] out_flit;
    logic [NP-1:0] out_ready;
    logic          busy;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int          src;
        int          dst;
        logic [11:0] flit;
    } sb_t;

    sb_t         sb[$];
    logic [11:0] held_f [NP];
    logic [NP-1:0] held_v = '0;

    always #5 clock = ~clock;

    mesh_router_xy #(
        .X_W        (2),
        .Y_W        (2),
        .PAYLOAD_W  (8),
        .FIFO_DEPTH (4),
        .MY_X       (MX),
        .MY_Y       (MY)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .block_all_paths (block_all_paths),
        .in_valid        (in_valid),
        .in_flit         (in_flit),
        .in_ready        (in_ready),
        .out_valid       (out_valid),
        .out_flit        (out_flit),
        .out_ready       (out_ready),
        .busy            (busy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [11:0] mkflit(input int x, input int y, input int pl);
        logic [1:0] xx;
        logic [1:0] yy;
        logic [7:0] pp;
        xx = x[1:0];
        yy = y[1:0];
        pp = pl[7:0];
        return {xx, yy, pp};
    endfunction

    // Reference XY decision from plain coordinate arithmetic
    function automatic int route_ref(input logic [11:0] f);
        int x;
        int y;
        x = int'(f[11:10]);
        y = int'(f[9:8]);
        if (x > MX) return 2;
        if (x < MX) return 4;
        if (y > MY) return 1;
        if (y < MY) return 3;
        return 0;
    endfunction

    task automatic set_flit(input int p, input logic [11:0] f);
        in_flit[p*FW +: FW] = f;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // A delivered flit must equal the oldest pending flit of some source
    // that is headed to this output
    task automatic sb_match(input int o, input logic [11:0] f);
        logic [NP-1:0] seen;
        int            hit;
        seen = '0;
        hit  = -1;
        for (int j = 0; j < sb.size(); j++) begin
            if (sb[j].dst == o && !seen[sb[j].src]) begin
                if (sb[j].flit == f) begin
                    hit = j;
                    break;
                end
                seen[sb[j].src] = 1'b1;
            end
        end
        checks++;
        if (hit < 0) begin
            failures++;
            $display("FAIL sb_match port %0d: got flit %03h, no pending flit expected there", o, f);
        end else begin
            sb.delete(hit);
        end
    endtask

    // Monitor: samples handshakes mid-cycle, ahead of the edge that commits them
    always @(negedge clock) begin
        logic [11:0] f;
        if (reset) begin
            sb.delete();
            held_v = '0;
        end else begin
            for (int o = 0; o < NP; o++) begin
                if (out_valid[o]) begin
                    f = out_flit[o*FW +: FW];
                    if (held_v[o]) chk($sformatf("hold_stable_p%0d", o), 64'(f), 64'(held_f[o]));
                    if (out_ready[o]) begin
                        sb_match(o, f);
                        held_v[o] = 1'b0;
                    end else begin
                        held_v[o] = 1'b1;
                        held_f[o] = f;
                    end
                end
            end
            for (int p = 0; p < NP; p++) begin
                if (in_valid[p] && in_ready[p]) begin
                    f = in_flit[p*FW +: FW];
                    sb.push_back('{p, route_ref(f), f});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        int          nvalid;
        int          nalt;
        int          sS;
        int          sW;
        int          tries;
        int          acc_blk;
        logic        accS;
        logic        accW;
        logic [3:0]  src_log [16];
        logic [7:0]  got [8];

        reset           = 1'b1;
        block_all_paths = 1'b0;
        in_valid        = '0;
        in_flit         = '0;
        out_ready       = '0;
        step();
        step();

        // Reset state
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'h1f);
        chk("rst_out_flit", 64'(out_flit), 64'(0));

        // Local injects {2,1,A5}: East output two edges later
        reset     = 1'b0;
        out_ready = 5'h1f;
        in_valid  = 5'b00001;
        set_flit(0, mkflit(2, 1, 8'hA5));
        step();
        in_valid = '0;
        chk("lat_not_early", 64'(out_valid), 64'(0));
        step();
        chk("lat_out_valid", 64'(out_valid), 64'b00100);
        chk("lat_flit", 64'(out_flit[2*FW +: FW]), 64'(mkflit(2, 1, 8'hA5)));
        step();

        // South and West both stream to Local: alternate one per cycle
        sS = 0;
        sW = 0;
        n  = 0;
        for (int c = 0; c < 14; c++) begin
            if (c < 10) begin
                in_valid = 5'b11000;
                set_flit(3, mkflit(1, 1, 8'h30 | (sS & 15)));
                set_flit(4, mkflit(1, 1, 8'h40 | (sW & 15)));
            end else begin
                in_valid = '0;
            end
            accS = in_valid[3] & in_ready[3];
            accW = in_valid[4] & in_ready[4];
            step();
            if (accS) sS++;
            if (accW) sW++;
            if (c >= 1 && c <= 11) begin
                src_log[n] = out_valid[0] ? out_flit[7:4] : 4'hF;
                n++;
            end
        end
        nvalid = 0;
        nalt   = 0;
        for (int j = 0; j < n; j++) begin
            if (src_log[j] != 4'hF) nvalid++;
            if (j > 0 && src_log[j] != src_log[j-1]) nalt++;
        end
        chk("rr_throughput", 64'(nvalid), 64'(11));
        chk("rr_first_south", 64'(src_log[0]), 64'(3));
        chk("rr_alternate", 64'(nalt), 64'(10));
        in_valid = '0;
        repeat (20) step();

        // North output stalled while North input offers five flits
        out_ready = 5'b11101;
        for (int s = 0; s < 5; s++) begin
            in_valid = 5'b00010;
            set_flit(1, mkflit(1, 2, 8'h10 + s));
            tries = 0;
            while (!in_ready[1] && tries < 20) begin
                step();
                tries++;
            end
            step();
            chk($sformatf("bp_in_ready_after_%0d", s + 1), 64'(in_ready[1]), 64'(s < 4 ? 1 : 0));
        end
        in_valid = '0;
        chk("bp_head_reg", 64'(out_flit[1*FW +: FW]), 64'(mkflit(1, 2, 8'h10)));
        repeat (3) step();
        chk("bp_still_full", 64'(in_ready[1]), 64'(0));
        chk("bp_out_valid", 64'(out_valid), 64'b00010);
        out_ready = 5'h1f;
        n = 0;
        for (int c = 0; c < 10; c++) begin
            if (out_valid[1] && out_ready[1] && n < 8) begin
                got[n] = out_flit[19:12];
                n++;
            end
            step();
        end
        chk("bp_count", 64'(n), 64'(5));
        for (int j = 0; j < 5; j++) chk($sformatf("bp_order_%0d", j), 64'(got[j]), 64'(8'h10 + j));
        repeat (4) step();

        // Block all paths with flits sitting in three output registers
        out_ready = '0;
        in_valid  = 5'b00111;
        set_flit(0, mkflit(2, 1, 8'h50));
        set_flit(1, mkflit(1, 0, 8'h51));
        set_flit(2, mkflit(0, 1, 8'h52));
        step();
        in_valid = '0;
        step();
        step();
        chk("blk_pre", 64'(out_valid), 64'b11100);
        block_all_paths = 1'b1;
        out_ready       = 5'h1f;
        acc_blk         = 0;
        for (int c = 0; c < 10; c++) begin
            in_valid = 5'($urandom) | 5'b00001;
            for (int p = 0; p < NP; p++)
                set_flit(p, mkflit($urandom_range(0, 3), $urandom_range(0, 3), 8'h60 | ((p * 10 + c) & 31)));
            for (int p = 0; p < NP; p++) if (in_valid[p] && in_ready[p]) acc_blk++;
            step();
            chk($sformatf("blk_out_valid_%0d", c), 64'(out_valid), 64'(0));
        end
        chk("blk_busy", 64'(busy), 64'(1));
        chk("blk_accepts", 64'(acc_blk > 0), 64'(1));
        in_valid        = '0;
        block_all_paths = 1'b0;
        #1;
        chk("blk_release", 64'(out_valid), 64'b11100);
        repeat (40) step();

        // One South->Local flit moves the Local pointer past South
        out_ready = 5'h1f;
        in_valid  = 5'b01000;
        set_flit(3, mkflit(1, 1, 8'h70));
        step();
        in_valid = '0;
        repeat (4) step();

        // Mid-stream reset
        out_ready = '0;
        for (int c = 0; c < 3; c++) begin
            in_valid = 5'h1f;
            for (int p = 0; p < NP; p++)
                set_flit(p, mkflit($urandom_range(0, 3), $urandom_range(0, 3), 8'h80 | c));
            step();
        end
        in_valid = '0;
        reset    = 1'b1;
        step();
        chk("mr_busy", 64'(busy), 64'(0));
        chk("mr_out_valid", 64'(out_valid), 64'(0));
        chk("mr_in_ready", 64'(in_ready), 64'h1f);
        chk("mr_out_flit", 64'(out_flit), 64'(0));
        reset     = 1'b0;
        out_ready = 5'h1f;

        // Fresh pointer: South wins over West again
        in_valid = 5'b11000;
        set_flit(3, mkflit(1, 1, 8'h73));
        set_flit(4, mkflit(1, 1, 8'h74));
        step();
        in_valid = '0;
        step();
        chk("mr_rr_first_valid", 64'(out_valid[0]), 64'(1));
        chk("mr_rr_first", 64'(out_flit[11:0]), 64'(mkflit(1, 1, 8'h73)));
        step();
        chk("mr_rr_second", 64'(out_flit[11:0]), 64'(mkflit(1, 1, 8'h74)));
        repeat (4) step();

        // Random traffic with random backpressure and occasional blocking
        for (int c = 0; c < 400; c++) begin
            in_valid = 5'($urandom);
            for (int p = 0; p < NP; p++)
                set_flit(p, mkflit($urandom_range(0, 3), $urandom_range(0, 3), (p << 5) | (c & 31)));
            out_ready       = 5'($urandom) | 5'($urandom);
            block_all_paths = ($urandom_range(0, 19) == 0);
            step();
        end

        // Drain and confirm nothing was lost
        in_valid        = '0;
        block_all_paths = 1'b0;
        out_ready       = 5'h1f;
        tries = 0;
        while (busy && tries < 300) begin
            step();
            tries++;
        end
        step();
        chk("drain_idle", 64'(busy), 64'(0));
        chk("sb_empty", 64'(sb.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
